// File: rtl/gba_sound_frame_seq_if.sv
// gba_sound_frame_seq_if
// Signal bundle between the sound register file (master) and the frame
// sequencer (slave). Channel blocks also read the strobe and power outputs.
//
// Transfer semantics: there is no valid/ready pair on this bus. ce,
// ch_trigger and ch_stop are single-cycle pulses, each sampled on exactly
// one rising clk edge. master_on is a level. The tick_* strobes are
// single-cycle pulses produced by the sequencer. step, gb_on and ch_active
// are registered levels. There is no back-pressure anywhere on this bus.
interface gba_sound_frame_seq_if;
    logic       ce;
    logic       master_on;
    logic [3:0] ch_trigger;
    logic [3:0] ch_stop;
    logic       gb_on;
    logic       tick_length;
    logic       tick_sweep;
    logic       tick_envelope;
    logic [2:0] step;
    logic [3:0] ch_active;
    logic       dbg_pwr_state;  // power FSM state: 0 = OFF, 1 = ON

    modport master (
        output ce, master_on, ch_trigger, ch_stop,
        input  gb_on, tick_length, tick_sweep, tick_envelope, step, ch_active,
        input  dbg_pwr_state
    );

    modport slave (
        input  ce, master_on, ch_trigger, ch_stop,
        output gb_on, tick_length, tick_sweep, tick_envelope, step, ch_active,
        output dbg_pwr_state
    );
endinterface

// File: rtl/gba_sound_frame_seq.sv
// gba_sound_frame_seq
// GBA PSG frame sequencer. It divides ce pulses down to the 512 Hz frame
// step and issues shared length (256 Hz), sweep (128 Hz) and envelope
// (64 Hz) strobes. It also owns the master power state and the per-channel
// active bits.
// Optional macro GBA_SOUND_SEQ_FAST_SIM_EN forces the divider period to 32.
// The divider width is not changed by this macro.
module gba_sound_frame_seq #(
    parameter int unsigned DIV_PERIOD = 32768,
    parameter int unsigned DIV_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gba_sound_frame_seq_if.slave  bus
);

`ifdef GBA_SOUND_SEQ_FAST_SIM_EN
    localparam int unsigned PERIOD = 32;
`else
    localparam int unsigned PERIOD = DIV_PERIOD;
`endif
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(PERIOD - 1);

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_t;

    pwr_state_t           state;
    pwr_state_t           state_next;
    logic                 run;
    logic [1:0]           rst_sync;
    logic                 rst_n_int;
    logic [DIV_WIDTH-1:0] div;
    logic [2:0]           step_q;
    logic [2:0]           step_next;
    logic                 tick_len_q;
    logic                 tick_swp_q;
    logic                 tick_env_q;
    logic [3:0]           active_q;

    // Reset assertion is immediate. Release passes through two flops, so the
    // first edge that does any work is the third edge after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // Power state register.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state <= PWR_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The datapath only advances while ON and while
    // master_on is still high. A cycle that drops master_on therefore
    // discards any wrap that lands on it.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            PWR_OFF: begin
                if (bus.master_on) begin
                    state_next = PWR_ON;
                end
            end
            PWR_ON: begin
                if (!bus.master_on) begin
                    state_next = PWR_OFF;
                end else begin
                    run = 1'b1;
                end
            end
        endcase
    end

    assign step_next = step_q + 3'd1;

    // Divider, step counter and strobes. The strobes are decoded from the
    // step being entered and are cleared on every other cycle.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            div        <= '0;
            step_q     <= 3'd7;
            tick_len_q <= 1'b0;
            tick_swp_q <= 1'b0;
            tick_env_q <= 1'b0;
        end else begin
            tick_len_q <= 1'b0;
            tick_swp_q <= 1'b0;
            tick_env_q <= 1'b0;
            if (!run) begin
                div    <= '0;
                step_q <= 3'd7;
            end else if (bus.ce) begin
                if (div == DIV_LAST) begin
                    div        <= '0;
                    step_q     <= step_next;
                    tick_len_q <= ~step_next[0];
                    tick_swp_q <= (step_next[1:0] == 2'b10);
                    tick_env_q <= (step_next == 3'd7);
                end else begin
                    div <= div + DIV_WIDTH'(1);
                end
            end
        end
    end

    // Channel status bits. A trigger overrides a stop in the same cycle.
    // All bits are held clear while powered off.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            active_q <= 4'b0000;
        end else if (!run) begin
            active_q <= 4'b0000;
        end else begin
            active_q <= (active_q & ~bus.ch_stop) | bus.ch_trigger;
        end
    end

    assign bus.gb_on         = (state == PWR_ON);
    assign bus.dbg_pwr_state = state;
    assign bus.tick_length   = tick_len_q;
    assign bus.tick_sweep    = tick_swp_q;
    assign bus.tick_envelope = tick_env_q;
    assign bus.step          = step_q;
    assign bus.ch_active     = active_q;

endmodule
